// File: rtl/seg7_digit_monitor.sv
// Receive-side checker for an active-low 7-segment digit bus: debounces, decodes and verifies a +1 mod 10 sequence.
// Define SEG7_MON_ALT_GLYPH_EN to also accept the alternate 6/7/9 glyphs.
module seg7_digit_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int PERIOD_W      = 26,
    parameter int ERR_W         = 8
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [6:0]          seg_in,
    output logic [3:0]          digit,
    output logic                digit_valid,
    output logic                digit_strobe,
    output logic                seq_error,
    output logic                illegal,
    output logic [ERR_W-1:0]    err_count,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid
);

    typedef enum logic {INIT, TRACK} state_t;

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);
    localparam logic [6:0] BLANK  = 7'b1111111;

    state_t              state_q, state_d;
    logic [6:0]          cand_q, cand_d, last_q, last_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [3:0]          ref_q, ref_d, digit_q, digit_d;
    logic                digit_valid_q, digit_valid_d, strobe_q, strobe_d;
    logic                seq_error_q, seq_error_d, illegal_q, illegal_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d, period_q, period_d;
    logic                period_valid_q, period_valid_d;

    logic                accept, dec_legal;
    logic [3:0]          dec_val;
    logic [6:0]          ag;

    // Bus bit 0 is segment a; flip so case labels read left-to-right as a..g.
    function automatic logic [6:0] to_ag(input logic [6:0] s);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) r[6-i] = s[i];
        return r;
    endfunction

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (seg_in != cand_q) begin
            cand_d = seg_in;
            cnt_d  = 8'(1);
        end else if (cnt_q != STABLE) begin
            cnt_d = cnt_q + 8'(1);
        end
        accept = (cnt_d == STABLE) && (cand_d != last_q);
    end

    always_comb begin
        ag        = to_ag(cand_d);
        dec_legal = 1'b1;
        dec_val   = 4'd0;
        case (ag)
            7'b0000001: dec_val = 4'd0;
            7'b1001111: dec_val = 4'd1;
            7'b0010010: dec_val = 4'd2;
            7'b0000110: dec_val = 4'd3;
            7'b1001100: dec_val = 4'd4;
            7'b0100100: dec_val = 4'd5;
            7'b0100000: dec_val = 4'd6;
            7'b0001111: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0000100: dec_val = 4'd9;
`ifdef SEG7_MON_ALT_GLYPH_EN
            7'b1100000: dec_val = 4'd6;
            7'b0001101: dec_val = 4'd7;
            7'b0001100: dec_val = 4'd9;
`endif
            default:    dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        ref_d          = ref_q;
        digit_d        = digit_q;
        digit_valid_d  = digit_valid_q;
        strobe_d       = 1'b0;
        seq_error_d    = 1'b0;
        illegal_d      = 1'b0;
        err_d          = err_q;
        period_d       = period_q;
        period_valid_d = period_valid_q;
        pcnt_d         = (&pcnt_q) ? pcnt_q : pcnt_q + PERIOD_W'(1);
        if (accept) begin
            last_d   = cand_d;
            strobe_d = 1'b1;
            if (dec_legal) begin
                digit_d       = dec_val;
                digit_valid_d = 1'b1;
                ref_d         = dec_val;
                pcnt_d        = '0;
                state_d       = TRACK;
                if (state_q == TRACK) begin
                    period_d       = (&pcnt_q) ? pcnt_q : pcnt_q + PERIOD_W'(1);
                    period_valid_d = 1'b1;
                    if (dec_val != ((ref_q == 4'd9) ? 4'd0 : ref_q + 4'd1)) begin
                        seq_error_d = 1'b1;
                        err_d       = (&err_q) ? err_q : err_q + ERR_W'(1);
                    end
                end
            end else begin
                // The next legal digit after garbage becomes a fresh reference.
                illegal_d      = 1'b1;
                err_d          = (&err_q) ? err_q : err_q + ERR_W'(1);
                digit_valid_d  = 1'b0;
                period_valid_d = 1'b0;
                state_d        = INIT;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q        <= INIT;
            cand_q         <= BLANK;
            last_q         <= BLANK;
            cnt_q          <= '0;
            ref_q          <= '0;
            digit_q        <= '0;
            digit_valid_q  <= 1'b0;
            strobe_q       <= 1'b0;
            seq_error_q    <= 1'b0;
            illegal_q      <= 1'b0;
            err_q          <= '0;
            pcnt_q         <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cand_q         <= cand_d;
            last_q         <= last_d;
            cnt_q          <= cnt_d;
            ref_q          <= ref_d;
            digit_q        <= digit_d;
            digit_valid_q  <= digit_valid_d;
            strobe_q       <= strobe_d;
            seq_error_q    <= seq_error_d;
            illegal_q      <= illegal_d;
            err_q          <= err_d;
            pcnt_q         <= pcnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
        end
    end

    assign digit        = digit_q;
    assign digit_valid  = digit_valid_q;
    assign digit_strobe = strobe_q;
    assign seq_error    = seq_error_q;
    assign illegal      = illegal_q;
    assign err_count    = err_q;
    assign period       = period_q;
    assign period_valid = period_valid_q;

endmodule
